// File: rtl/ray_thread_dispatcher_pkg.sv
// ray_thread_dispatcher_pkg: shared renderer types for the ray thread dispatcher
`ifndef RAY_CORE_SIZE
`define RAY_CORE_SIZE 4
`endif
package ray_thread_dispatcher_pkg;
    localparam int RAY_CORE_SIZE = `RAY_CORE_SIZE;
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] index;
    } DispatchData;
    typedef enum logic { SCAN_RASTER = 1'b0, SCAN_TILED = 1'b1 } ScanMode;
    typedef enum logic [1:0] { ST_IDLE, ST_RUN, ST_DONE } dispatch_state_e;
    function automatic logic [31:0] pixel_index(input logic [15:0] x, input logic [15:0] y, input int unsigned width);
        return 32'(y) * 32'(width) + 32'(x);
    endfunction
endpackage

// File: rtl/ray_thread_dispatcher_if.sv
// ray_thread_dispatcher_if: per-core thread issue bus between dispatcher and ray cores
interface ray_thread_dispatcher_if import ray_thread_dispatcher_pkg::*; #(
    parameter int NUM_CORES = `RAY_CORE_SIZE
) ();
    logic [NUM_CORES-1:0] core_full;
    logic [NUM_CORES-1:0] out_valid;
    DispatchData [NUM_CORES-1:0] out_data;
    modport master (input core_full, output out_valid, output out_data);
    modport slave (output core_full, input out_valid, input out_data);
endinterface

// File: rtl/ray_thread_dispatcher_arbiter.sv
// round_robin_arbiter: picks the first requesting core after the last grant
module round_robin_arbiter #(
    parameter int NUM_CORES = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic [NUM_CORES-1:0] request,
    input  logic                 advance,
    output logic [NUM_CORES-1:0] grant,
    output logic                 grant_valid
);
    localparam int PW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
    logic [PW-1:0] ptr_q, ptr_d, pick;
    int unsigned idx;
    // circular search from ptr_q; scanning offsets downward lets the nearest requester win
    always_comb begin
        grant = '0;
        grant_valid = 1'b0;
        pick = ptr_q;
        idx = 0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NUM_CORES;
            if (request[idx]) begin
                pick = PW'(idx);
                grant_valid = 1'b1;
            end
        end
        grant[pick] = grant_valid;
        ptr_d = clear ? '0 :
                (advance && grant_valid) ? (pick == PW'(NUM_CORES - 1) ? '0 : pick + PW'(1)) :
                ptr_q;
    end
    // priority pointer register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ptr_q <= '0;
        else ptr_q <= ptr_d;
    end
endmodule

// File: rtl/ray_thread_dispatcher.sv
// ray_thread_dispatcher: walks a frame in raster or tiled order and issues one pixel per cycle to free cores
module ray_thread_dispatcher import ray_thread_dispatcher_pkg::*; #(
    parameter int NUM_CORES = `RAY_CORE_SIZE,
    parameter int WIDTH_PX  = 640,
    parameter int HEIGHT_PX = 480,
    parameter int TILE_SIZE = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        strobe,
    input  logic                        tile_mode,
    ray_thread_dispatcher_if.master     bus,
    output logic                        busy,
    output logic                        frame_done,
    output logic [NUM_CORES-1:0][31:0]  core_pixel_count,
    output logic [31:0]                 pixel_count
);
    localparam logic [15:0] XMAX = 16'(WIDTH_PX - 1);
    localparam logic [15:0] YMAX = 16'(HEIGHT_PX - 1);
    localparam logic [15:0] TMAX = 16'(TILE_SIZE - 1);
    dispatch_state_e state_q, state_d;
    ScanMode mode_q, mode_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic [NUM_CORES-1:0] valid_q, grant;
    DispatchData [NUM_CORES-1:0] data_q;
    logic [NUM_CORES-1:0][31:0] ccnt_q;
    logic [31:0] pcnt_q;
    logic grant_valid, accept, issue, last;

    assign accept = state_q == ST_IDLE && strobe;
    assign issue  = state_q == ST_RUN && grant_valid;
    assign last   = x_q == XMAX && y_q == YMAX;

    round_robin_arbiter #(.NUM_CORES(NUM_CORES)) u_arb (
        .clk         (clk),
        .resetn      (resetn),
        .clear       (accept),
        .request     (~bus.core_full),
        .advance     (issue),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // FSM next state: one frame per accepted strobe, DONE lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = strobe ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = (issue && last) ? ST_DONE : ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // coordinate walker; the final pixel is (XMAX,YMAX) in both orders
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        mode_d = accept ? ScanMode'(tile_mode) : mode_q;
        if (accept) begin
            x_d = '0;
            y_d = '0;
        end else if (issue) begin
            if (mode_q == SCAN_RASTER) begin
                x_d = x_q == XMAX ? '0 : x_q + 16'd1;
                y_d = x_q == XMAX ? y_q + 16'd1 : y_q;
            end else if ((x_q & TMAX) != TMAX) begin
                x_d = x_q + 16'd1;
            end else if ((y_q & TMAX) != TMAX) begin
                x_d = x_q - TMAX;
                y_d = y_q + 16'd1;
            end else if (x_q == XMAX) begin
                x_d = '0;
                y_d = y_q + 16'd1;
            end else begin
                x_d = x_q + 16'd1;
                y_d = y_q - TMAX;
            end
        end
    end

    // state, walker and scan mode registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            mode_q  <= SCAN_RASTER;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // registered issue outputs and per-frame counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            data_q  <= '0;
            ccnt_q  <= '0;
            pcnt_q  <= '0;
        end else begin
            valid_q <= issue ? grant : '0;
            for (int i = 0; i < NUM_CORES; i++)
                if (issue && grant[i]) data_q[i] <= '{x: x_q, y: y_q, index: pixel_index(x_q, y_q, WIDTH_PX)};
            if (accept) begin
                ccnt_q <= '0;
                pcnt_q <= '0;
            end else if (issue) begin
                pcnt_q <= pcnt_q + 32'd1;
                for (int i = 0; i < NUM_CORES; i++)
                    if (grant[i]) ccnt_q[i] <= ccnt_q[i] + 32'd1;
            end
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_data       = data_q;
    assign busy               = state_q != ST_IDLE;
    assign frame_done         = state_q == ST_DONE;
    assign core_pixel_count   = ccnt_q;
    assign pixel_count        = pcnt_q;
endmodule

// File: tb/tb_ray_thread_dispatcher.sv
// tb_ray_thread_dispatcher: directed checks of ray_thread_dispatcher on an 8x4 frame with 4x4 tiles
module tb_ray_thread_dispatcher;
    import ray_thread_dispatcher_pkg::*;
    localparam int NC = 4, W = 8, H = 4, T = 4;
    logic clk = 1'b0, resetn = 1'b0, strobe = 1'b0, tile_mode = 1'b0;
    logic busy, frame_done;
    logic [NC-1:0][31:0] core_pixel_count;
    logic [31:0] pixel_count;
    typedef struct { int core; int x; int y; int idx; } iss_t;
    iss_t log_q[$];
    int fd_cnt = 0, fd_with_valid = 0, multi_cnt = 0;
    int total = 0, bad = 0;

    ray_thread_dispatcher_if #(.NUM_CORES(NC)) bus ();

    ray_thread_dispatcher #(.NUM_CORES(NC), .WIDTH_PX(W), .HEIGHT_PX(H), .TILE_SIZE(T)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .strobe           (strobe),
        .tile_mode        (tile_mode),
        .bus              (bus),
        .busy             (busy),
        .frame_done       (frame_done),
        .core_pixel_count (core_pixel_count),
        .pixel_count      (pixel_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ($countones(bus.out_valid) > 1) multi_cnt++;
        for (int i = 0; i < NC; i++)
            if (bus.out_valid[i])
                log_q.push_back('{i, int'(bus.out_data[i].x), int'(bus.out_data[i].y), int'(bus.out_data[i].index)});
        if (frame_done) begin
            fd_cnt++;
            if (|bus.out_valid) fd_with_valid++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_q.delete();
        fd_cnt = 0;
        fd_with_valid = 0;
        multi_cnt = 0;
    endtask

    task automatic start_frame(input logic tm);
        @(negedge clk);
        tile_mode = tm;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (busy && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_timeout"}, 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic count_issues(input int n);
        int seen = 0, c = 0;
        while (seen < n && c < 200) begin
            @(negedge clk);
            if (|bus.out_valid) seen++;
            c++;
        end
        chk("issue_wait", 64'(seen), 64'(n));
    endtask

    initial begin
        int errs;
        int ex[$], ey[$];
        int cyc3[3] = '{0, 2, 3};
        bus.core_full = '0;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_pcnt", 64'(pixel_count), 64'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_strobe", 64'(busy), 64'd0);

        // raster, no full cores
        clear_log();
        start_frame(1'b0);
        chk("run_busy", 64'(busy), 64'd1);
        chk("first_cycle_no_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("first_valid", 64'(bus.out_valid), 64'h1);
        chk("first_data", 64'(bus.out_data[0]), {16'd0, 16'd0, 32'd0});
        wait_idle("raster");
        chk("raster_size", 64'(log_q.size()), 64'd32);
        errs = 0;
        foreach (log_q[i])
            if (log_q[i].core != i % 4 || log_q[i].x != i % 8 || log_q[i].y != i / 8 || log_q[i].idx != i) errs++;
        chk("raster_order", 64'(errs), 64'd0);
        for (int i = 0; i < NC; i++) chk("raster_core_cnt", 64'(core_pixel_count[i]), 64'd8);
        chk("raster_pcnt", 64'(pixel_count), 64'd32);
        chk("raster_fd", 64'(fd_cnt), 64'd1);
        chk("raster_fd_with_valid", 64'(fd_with_valid), 64'd1);
        chk("raster_onehot", 64'(multi_cnt), 64'd0);
        chk("hold_data3", 64'(bus.out_data[3]), {16'd7, 16'd3, 32'd31});
        chk("hold_data0", 64'(bus.out_data[0]), {16'd4, 16'd3, 32'd28});

        // tiled
        for (int tx = 0; tx < W / T; tx++)
            for (int ly = 0; ly < T; ly++)
                for (int lx = 0; lx < T; lx++) begin
                    ex.push_back(tx * T + lx);
                    ey.push_back(ly);
                end
        clear_log();
        start_frame(1'b1);
        wait_idle("tiled");
        chk("tiled_size", 64'(log_q.size()), 64'd32);
        if (log_q.size() == 32) begin
            chk("tiled_5th", {32'(log_q[4].x), 32'(log_q[4].y)}, {32'd0, 32'd1});
            chk("tiled_17th", {16'(log_q[16].x), 16'(log_q[16].y), 32'(log_q[16].idx)}, {16'd4, 16'd0, 32'd4});
            chk("tiled_last", {16'(log_q[31].x), 16'(log_q[31].y), 32'(log_q[31].idx)}, {16'd7, 16'd3, 32'd31});
        end
        errs = 0;
        foreach (log_q[i])
            if (i < 32 && (log_q[i].x != ex[i] || log_q[i].y != ey[i] || log_q[i].idx != ey[i] * W + ex[i] || log_q[i].core != i % 4)) errs++;
        chk("tiled_order", 64'(errs), 64'd0);
        chk("tiled_fd", 64'(fd_cnt), 64'd1);

        // core 1 permanently full
        clear_log();
        bus.core_full = 4'b0010;
        start_frame(1'b0);
        wait_idle("skip1");
        bus.core_full = '0;
        chk("skip1_size", 64'(log_q.size()), 64'd32);
        errs = 0;
        foreach (log_q[i])
            if (log_q[i].core != cyc3[i % 3] || log_q[i].idx != i) errs++;
        chk("skip1_order", 64'(errs), 64'd0);
        chk("skip1_cnt0", 64'(core_pixel_count[0]), 64'd11);
        chk("skip1_cnt1", 64'(core_pixel_count[1]), 64'd0);
        chk("skip1_cnt2", 64'(core_pixel_count[2]), 64'd11);
        chk("skip1_cnt3", 64'(core_pixel_count[3]), 64'd10);

        // all cores full for 5 cycles after the 10th issue
        clear_log();
        start_frame(1'b0);
        count_issues(10);
        bus.core_full = 4'hF;
        errs = 0;
        repeat (5) begin
            @(negedge clk);
            if (|bus.out_valid) errs++;
        end
        chk("stall_quiet", 64'(errs), 64'd0);
        bus.core_full = '0;
        wait_idle("stall");
        chk("stall_size", 64'(log_q.size()), 64'd32);
        if (log_q.size() > 10)
            chk("stall_11th", {16'(log_q[10].x), 16'(log_q[10].y), 32'(log_q[10].idx)}, {16'd2, 16'd1, 32'd10});
        errs = 0;
        foreach (log_q[i]) if (log_q[i].idx != i) errs++;
        chk("stall_nodup", 64'(errs), 64'd0);
        chk("stall_pcnt", 64'(pixel_count), 64'd32);

        // reset mid-frame
        clear_log();
        start_frame(1'b0);
        count_issues(12);
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_pcnt", 64'(pixel_count), 64'd0);
        chk("mid_rst_ccnt", 64'(core_pixel_count[0] | core_pixel_count[1] | core_pixel_count[2] | core_pixel_count[3]), 64'd0);
        chk("mid_rst_data", 64'(bus.out_data[3] | bus.out_data[0]), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        errs = 0;
        repeat (10) begin
            @(negedge clk);
            if ((|bus.out_valid) || busy) errs++;
        end
        chk("post_rst_quiet", 64'(errs), 64'd0);
        clear_log();
        start_frame(1'b0);
        wait_idle("post_rst");
        chk("post_rst_size", 64'(log_q.size()), 64'd32);
        if (log_q.size() > 0)
            chk("post_rst_first", {16'(log_q[0].core), 16'(log_q[0].x), 32'(log_q[0].y)}, 64'd0);

        // strobe held high across a whole frame
        clear_log();
        @(negedge clk);
        tile_mode = 1'b0;
        strobe = 1'b1;
        @(negedge clk);
        begin
            int c = 0;
            while (busy && c < 300) begin
                @(negedge clk);
                c++;
            end
        end
        chk("held_idle", 64'(busy), 64'd0);
        chk("held_size", 64'(log_q.size()), 64'd32);
        chk("held_fd", 64'(fd_cnt), 64'd1);
        @(negedge clk);
        chk("held_restart", 64'(busy), 64'd1);
        strobe = 1'b0;
        wait_idle("held2");
        chk("held2_size", 64'(log_q.size()), 64'd64);
        chk("held2_fd", 64'(fd_cnt), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
